// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: VGA pixel/line counters plus a once-per-frame
// update window granted to game logic during vertical blanking.
// Ports: clk, reset (sync, active-high), ce (pixel enable),
//   HCount/VCount (counters), active (visible area), frame_tick (last
//   pixel of frame), upd_req/upd_done (update handshake in),
//   upd_grant (window owned), upd_overrun (grant revoked at frame end).
module vga_frame_scheduler #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    output logic [10:0] HCount,
    output logic [10:0] VCount,
    output logic        active,
    output logic        frame_tick,
    input  logic        upd_req,
    input  logic        upd_done,
    output logic        upd_grant,
    output logic        upd_overrun
);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLANK,
        GRANT,
        DONE
    } state_t;

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    state_t      r_state;
    state_t      w_next_state;
    logic        r_overrun;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_vblank;
    logic        w_frame_tick;
    logic        w_revoke;

    assign w_h_last     = (r_hcount == H_LAST);
    assign w_v_last     = (r_vcount == V_LAST);
    assign w_vblank     = (r_vcount >= V_ACT);
    assign w_frame_tick = ce & w_h_last & w_v_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (ce) begin
            if (w_h_last) begin
                r_hcount <= '0;
                r_vcount <= w_v_last ? '0 : r_vcount + 11'd1;
            end else begin
                r_hcount <= r_hcount + 11'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_revoke     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (upd_req) w_next_state = WAIT_BLANK;
            end
            WAIT_BLANK: begin
                // On the frame tick the counters are about to wrap out
                // of blanking, so a grant there would be zero-length.
                if (w_vblank && !w_frame_tick) w_next_state = GRANT;
            end
            GRANT: begin
                if (upd_done) begin
                    w_next_state = DONE;
                end else if (w_frame_tick) begin
                    w_next_state = IDLE;
                    w_revoke     = 1'b1;
                end
            end
            DONE: begin
                // Parking here until the frame ends caps grants at one.
                if (w_frame_tick) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_overrun <= w_revoke;
        end
    end

    assign HCount      = r_hcount;
    assign VCount      = r_vcount;
    assign active      = (r_hcount < H_ACT) && (r_vcount < V_ACT);
    assign frame_tick  = w_frame_tick;
    assign upd_grant   = (r_state == GRANT);
    assign upd_overrun = r_overrun;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler: randomized check of vga_frame_scheduler
// against a pixel-index and event-flag reference model.
module tb_vga_frame_scheduler;

    localparam int HT = 20;
    localparam int VT = 12;
    localparam int HA = 16;
    localparam int VA = 8;
    localparam int FR = HT * VT;

    logic        clk;
    logic        reset;
    logic        ce;
    logic [10:0] HCount;
    logic [10:0] VCount;
    logic        active;
    logic        frame_tick;
    logic        upd_req;
    logic        upd_done;
    logic        upd_grant;
    logic        upd_overrun;

    int n_chk;
    int n_err;
    int n_ft_dut;
    int n_ft_ref;
    int n_grants;
    int n_ovr;

    // Reference: position in the frame as one pixel index, and the
    // update window as a few event flags.
    int m_idx;
    bit m_wait;
    bit m_grant;
    bit m_used;
    bit m_ovr;

    vga_frame_scheduler #(
        .H_TOTAL (HT),
        .V_TOTAL (VT),
        .H_ACTIVE(HA),
        .V_ACTIVE(VA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .HCount     (HCount),
        .VCount     (VCount),
        .active     (active),
        .frame_tick (frame_tick),
        .upd_req    (upd_req),
        .upd_done   (upd_done),
        .upd_grant  (upd_grant),
        .upd_overrun(upd_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int mode, input bit rst_force);
        bit ft;
        bit vb;
        int h;
        int v;
        @(negedge clk);
        h = m_idx % HT;
        v = m_idx / HT;
        unique case (mode)
            0, 3:    ce = 1'b1;
            1:       ce = ~ce;
            default: ce = ($urandom_range(0, 2) != 0);
        endcase
        ft = ce && (m_idx == FR - 1);
        vb = (v >= VA);
        upd_req = ($urandom_range(0, 3) != 0);
        unique case (mode)
            2:       upd_done = 1'b0;
            3:       upd_done = ft && m_grant;
            default: upd_done = ($urandom_range(0, 24) == 0);
        endcase
        reset = rst_force ||
                (mode == 4 && m_grant && v >= VA + 2 &&
                 $urandom_range(0, 3) == 0);
        #1;
        chk("hcount", 32'(HCount), h);
        chk("vcount", 32'(VCount), v);
        chk("active", 32'(active), 32'(h < HA && v < VA));
        chk("frame_tick", 32'(frame_tick), 32'(ft));
        chk("grant", 32'(upd_grant), 32'(m_grant));
        chk("overrun", 32'(upd_overrun), 32'(m_ovr));
        if (frame_tick) n_ft_dut++;
        if (ft) n_ft_ref++;
        if (m_grant) n_grants++;
        if (m_ovr) n_ovr++;
        if (reset) begin
            m_idx   = 0;
            m_wait  = 0;
            m_grant = 0;
            m_used  = 0;
            m_ovr   = 0;
        end else begin
            m_ovr = 0;
            if (m_grant) begin
                if (upd_done) begin
                    m_grant = 0;
                    m_used  = 1;
                end else if (ft) begin
                    m_grant = 0;
                    m_ovr   = 1;
                end
            end else if (m_used) begin
                if (ft) m_used = 0;
            end else if (m_wait) begin
                if (vb && !ft) begin
                    m_wait  = 0;
                    m_grant = 1;
                end
            end else if (upd_req) begin
                m_wait = 1;
            end
            if (ce) m_idx = (m_idx + 1) % FR;
        end
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        n_ft_dut = 0;
        n_ft_ref = 0;
        n_grants = 0;
        n_ovr    = 0;
        m_idx    = 0;
        m_wait   = 0;
        m_grant  = 0;
        m_used   = 0;
        m_ovr    = 0;
        reset    = 1'b1;
        ce       = 1'b0;
        upd_req  = 1'b0;
        upd_done = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 1'b1);
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 3000; c++) step(p, 1'b0);
        end
        chk("tick_count", n_ft_dut, n_ft_ref);
        chk("saw_grant", 32'(n_grants > 0), 32'd1);
        chk("saw_overrun", 32'(n_ovr > 0), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_frame_scheduler.md
Name: vga_frame_scheduler

Overview:
- Generates the VGA horizontal and vertical pixel counters that drive the sync generator and the pixel pipeline.
- Arbitrates a once-per-frame update window for game/state logic, so that sprite positions and registers change only during vertical blanking.
- Sits between the pixel-clock enable and both the sync decode and the game-state update logic.

Parameters:
- H_TOTAL, 800, pixels per line including blanking.
- V_TOTAL, 525, lines per frame including blanking.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ce  input  1  pixel-clock enable; counters advance only when high.
- HCount  output  11  horizontal pixel index, 0..H_TOTAL-1.
- VCount  output  11  vertical line index, 0..V_TOTAL-1.
- active  output  1  high when HCount<H_ACTIVE and VCount<V_ACTIVE.
- frame_tick  output  1  one-cycle pulse on the last pixel of the frame.
- upd_req  input  1  level request from update logic; held until granted.
- upd_done  input  1  one-cycle pulse from update logic; update finished.
- upd_grant  output  1  high while update logic owns the blanking window.
- upd_overrun  output  1  one-cycle pulse when a grant is revoked at frame end.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. All registers clear on reset regardless of ce.
- Reset values: HCount=0, VCount=0, state=IDLE, upd_grant=0, upd_overrun=0. Therefore active=1 and frame_tick=0 out of reset.
- Counters: registered; they hold when ce=0.
  - On ce, HCount increments.
  - At HCount=H_TOTAL-1, HCount wraps to 0 and VCount increments.
  - At VCount=V_TOTAL-1 with HCount=H_TOTAL-1, both wrap to 0.
  - Counts never exceed TOTAL-1. Widths are 11 bits; compares are unsigned.
- active: combinational from the registered counters.
- frame_tick: combinational. It equals ce & (HCount==H_TOTAL-1) & (VCount==V_TOTAL-1), so it is high exactly one clk cycle per frame.
- vblank = VCount>=V_ACTIVE, combinational.
- FSM states: IDLE, WAIT_BLANK, GRANT, DONE.
  - IDLE: upd_req=1 -> WAIT_BLANK.
  - WAIT_BLANK: vblank & ~frame_tick -> GRANT; otherwise stay.
  - GRANT:
    - upd_done=1 -> DONE.
    - Else frame_tick=1 -> IDLE, and upd_overrun pulses for 1 cycle.
    - upd_done and frame_tick in the same cycle -> DONE; done wins and there is no overrun.
  - DONE: frame_tick=1 -> IDLE. This limits grants to one per frame.
- upd_grant = (state==GRANT), registered Moore output.
  - Latency: upd_grant rises 1 clk after the cycle in which WAIT_BLANK sees vblank.
  - upd_grant falls 1 clk after upd_done or after frame_tick.
- upd_req dropping while in WAIT_BLANK is ignored; the grant is still issued. Update logic must tolerate this.
- upd_done outside GRANT is ignored.
- A request arriving during vblank is granted within 2 clk: IDLE->WAIT_BLANK->GRANT.
- Reset mid-grant drops upd_grant on the next edge. No overrun pulse is issued.
- upd_overrun is registered. It is high for the cycle after the revoking frame_tick and is 0 otherwise.

Test Plan:
- Reset, then ce held high for 420000 cycles:
  - HCount sequence is 0..799 repeating; VCount steps at each H wrap, 0..524.
  - frame_tick pulses exactly once per 420000 cycles, at (799,524).
  - active is low at H=640 and at V=480.
- ce toggling 1/0:
  - Counters hold on ce=0 cycles.
  - One frame takes 840000 clk.
  - frame_tick is never high while ce=0.
- upd_req asserted at V=100:
  - FSM waits until VCount=480.
  - upd_grant rises 1 clk after VCount first reads 480.
  - upd_done at V=490 -> upd_grant low next clk.
  - No second grant until after frame_tick, even with upd_req held high.
- Grant issued, upd_done never sent:
  - upd_grant drops the clk after frame_tick at (799,524).
  - upd_overrun is high for exactly that 1 cycle.
  - State returns to IDLE.
- upd_done coincident with frame_tick -> DONE, no overrun, and DONE exits on that same tick's next frame_tick.
- reset asserted mid-GRANT at V=500 -> next clk: HCount=0, VCount=0, upd_grant=0, upd_overrun=0.
